// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the single-issue LEGv8 core. Owns the PC, runs a
// request/acknowledge handshake with a variable-latency instruction memory
// and holds the fetched word in the IF register (instr, pc, valid) that
// feeds decode.
//
// Memory handshake: o_imem_req is a level that stays high until the cycle
// i_imem_ack pulses. o_imem_addr is stable for the whole transaction.
// Exactly one ack is owed per request, even if the request has been made
// stale by a redirect. A stale transaction's data is dropped on arrival.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            asynchronous, active-high reset
//   o_imem_req       fetch request, held until i_imem_ack
//   o_imem_addr      fetch address, stable while o_imem_req=1
//   i_imem_ack       single-cycle pulse: i_imem_rdata valid, transaction done
//   i_imem_rdata     fetched instruction word
//   i_stall          decode cannot consume the IF register this cycle
//   i_branch_taken   single-cycle redirect pulse
//   i_branch_target  redirect address, bits [1:0] forced to zero
//   o_if_valid       IF register holds a valid instruction
//   o_if_instr       IF register instruction
//   o_if_pc          address of o_if_instr
//   o_dbg_state      current FSM state (0 = REQ, 1 = FULL)
//   o_dbg_discard    outstanding transaction will be dropped on ack
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter int                 ADDR_W   = 64,
   parameter int                 INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic               o_imem_req,
   output logic [ADDR_W-1:0]  o_imem_addr,
   input  logic               i_imem_ack,
   input  logic [INSTR_W-1:0] i_imem_rdata,
   input  logic               i_stall,
   input  logic               i_branch_taken,
   input  logic [ADDR_W-1:0]  i_branch_target,
   output logic               o_if_valid,
   output logic [INSTR_W-1:0] o_if_instr,
   output logic [ADDR_W-1:0]  o_if_pc,
   output logic               o_dbg_state,
   output logic               o_dbg_discard
);

   typedef enum logic {
      ST_REQ  = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
   logic [ADDR_W-1:0]   r_fetch_addr, w_fetch_addr_nxt;
   logic                r_discard, w_discard_nxt;
   logic                r_if_valid, w_if_valid_nxt;
   logic [INSTR_W-1:0]  r_if_instr, w_if_instr_nxt;
   logic [ADDR_W-1:0]   r_if_pc, w_if_pc_nxt;
   logic [ADDR_W-1:0]   w_target;

   assign w_target = i_branch_target & ~ADDR_W'(3);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_REQ;
         r_pc         <= RESET_PC;
         r_fetch_addr <= RESET_PC;
         r_discard    <= 1'b0;
         r_if_valid   <= 1'b0;
         r_if_instr   <= '0;
         r_if_pc      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_fetch_addr <= w_fetch_addr_nxt;
         r_discard    <= w_discard_nxt;
         r_if_valid   <= w_if_valid_nxt;
         r_if_instr   <= w_if_instr_nxt;
         r_if_pc      <= w_if_pc_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_fetch_addr_nxt = r_fetch_addr;
      w_discard_nxt    = r_discard;
      w_if_valid_nxt   = r_if_valid;
      w_if_instr_nxt   = r_if_instr;
      w_if_pc_nxt      = r_if_pc;

      if (i_branch_taken) begin
         // Redirect wins over stall and ack in every state.
         w_pc_nxt       = w_target;
         w_if_valid_nxt = 1'b0;
         if (r_state == ST_FULL) begin
            w_fetch_addr_nxt = w_target;
            w_state_nxt      = ST_REQ;
         end else if (i_imem_ack) begin
            // The owed ack is here: drop its data and start the target
            // fetch next cycle with nothing left to discard.
            w_fetch_addr_nxt = w_target;
            w_discard_nxt    = 1'b0;
         end else begin
            // Old transaction still in flight: keep its address stable and
            // remember to throw its data away.
            w_discard_nxt = 1'b1;
         end
      end else if (r_state == ST_REQ) begin
         if (i_imem_ack) begin
            if (r_discard) begin
               // Stale ack: re-request at the redirected PC.
               w_discard_nxt    = 1'b0;
               w_fetch_addr_nxt = r_pc;
            end else begin
               w_if_instr_nxt = i_imem_rdata;
               w_if_pc_nxt    = r_fetch_addr;
               w_if_valid_nxt = 1'b1;
               w_pc_nxt       = r_fetch_addr + ADDR_W'(4);
               w_state_nxt    = ST_FULL;
            end
         end
      end else begin
         if (!i_stall) begin
            w_if_valid_nxt   = 1'b0;
            w_fetch_addr_nxt = r_pc;
            w_state_nxt      = ST_REQ;
         end
      end
   end

   assign o_imem_req    = (r_state == ST_REQ);
   assign o_imem_addr   = r_fetch_addr;
   assign o_if_valid    = r_if_valid;
   assign o_if_instr    = r_if_instr;
   assign o_if_pc       = r_if_pc;
   assign o_dbg_state   = r_state;
   assign o_dbg_discard = r_discard;

endmodule
